// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV32I data-memory responder (MEM-stage target)
//
// Accepts one load/store at a time over a req_valid/req_ready handshake, waits
// WAIT_CYCLES, performs a byte/half/word access with RV32I extension rules and
// returns a one-cycle rsp_valid strobe. busy stalls the pipeline meanwhile.
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   - misaligned accesses are suppressed and flagged on rsp_err
//   undefined - rsp_err is 0; misaligned addresses are rounded down
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr              byte address (DM_ADDRESS bits)
//   req_wdata             store data (low lanes used)
//   req_funct3            RV32I funct3 of the load/store
//   rsp_valid             one-cycle response strobe
//   rsp_rdata             extended load data, 0 for stores (held until next response)
//   rsp_err               misalignment error, qualified by rsp_valid
//   busy                  request outstanding
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int WORDS = 1 << (DM_ADDRESS - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic                  lat_write;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [2:0]            lat_funct3;

  logic [DATA_W-1:0] mem [WORDS];

  logic                  is_half, is_word, misaligned, blocked, store_ok, mem_we;
  logic [1:0]            eff_off;
  logic [DM_ADDRESS-3:0] word_idx;
  logic [DATA_W-1:0]     rd_word, rd_shift, wr_word, load_data, acc_rdata;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  acc_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // Response registers only change on the ACCESS -> RESP transition.
      if (state == S_ACCESS) begin
        rsp_rdata <= acc_rdata;
        rsp_err   <= acc_err;
      end
    end
  end

  // Request capture; datapath only, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      lat_write  <= req_write;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      lat_funct3 <= req_funct3;
    end
  end

  // Memory has no reset: contents survive a reset, and a store committed in
  // ACCESS is written even if reset arrives in that same cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = S_ACCESS;
      end
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP) && !reset;
  assign busy      = (state != S_IDLE) || req_valid;

  always_comb begin
    // funct3 101 is only a halfword for loads; as a store it is invalid.
    is_half    = (lat_funct3[1:0] == 2'b01) && (!lat_write || !lat_funct3[2]);
    is_word    = (lat_funct3 == 3'b010);
    misaligned = (is_half && lat_addr[0]) || (is_word && (lat_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_ERR_EN
    blocked = misaligned;
`else
    blocked = 1'b0;
`endif
    eff_off = lat_addr[1:0];
    if (is_half) eff_off[0] = 1'b0;
    if (is_word) eff_off    = 2'b00;

    word_idx = lat_addr[DM_ADDRESS-1:2];
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {eff_off, 3'b000};
    byte_sel = rd_shift[7:0];
    half_sel = eff_off[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    case (lat_funct3)
      3'b000:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b001:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase

    // Read-modify-write merge keeps unwritten lanes.
    wr_word  = rd_word;
    store_ok = 1'b1;
    case (lat_funct3)
      3'b000:  wr_word[{eff_off, 3'b000} +: 8]        = lat_wdata[7:0];
      3'b001:  wr_word[{eff_off[1], 4'b0000} +: 16]   = lat_wdata[15:0];
      3'b010:  wr_word                                = lat_wdata;
      default: store_ok = 1'b0;
    endcase

    mem_we    = (state == S_ACCESS) && lat_write && store_ok && !blocked;
    acc_rdata = (lat_write || blocked) ? '0 : load_data;
    acc_err   = blocked;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with byte-array reference model
module tb_dmem_responder;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [2:0]    req_funct3;
  logic          req_ready, rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;

  dmem_responder #(.DM_ADDRESS(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [7:0]  mb [0:511];
  logic [31:0] last_rdata;
  logic        last_err;
  logic        bp_watch = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model over a flat byte array, little-endian.
  task automatic model(input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] f3, output logic [31:0] rd, output logic err);
    logic half, word, mis;
    int ea;
    half = (f3[1:0] == 2'b01) && (!w || !f3[2]);
    word = (f3 == 3'b010);
    mis  = (half && a[0]) || (word && a[1:0] != 2'b00);
    rd   = 32'h0;
    err  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    if (mis) begin
      err = 1'b1;
      return;
    end
`endif
    ea = int'(a);
    if (half) ea = ea - (ea % 2);
    if (word) ea = ea - (ea % 4);
    if (w) begin
      if (f3 == 3'b000) mb[ea] = d[7:0];
      if (f3 == 3'b001) begin mb[ea] = d[7:0]; mb[ea+1] = d[15:8]; end
      if (f3 == 3'b010) begin
        mb[ea] = d[7:0]; mb[ea+1] = d[15:8]; mb[ea+2] = d[23:16]; mb[ea+3] = d[31:24];
      end
    end else begin
      case (f3)
        3'b000: rd = {{24{mb[ea][7]}}, mb[ea]};
        3'b100: rd = {24'h0, mb[ea]};
        3'b001: rd = {{16{mb[ea+1][7]}}, mb[ea+1], mb[ea]};
        3'b101: rd = {16'h0, mb[ea+1], mb[ea]};
        3'b010: rd = {mb[ea+3], mb[ea+2], mb[ea+1], mb[ea]};
        default: rd = 32'h0;
      endcase
    end
  endtask

  // Monitor: pops expectations on every response, checks stall outputs in between.
  always @(negedge clk) begin
    if (!reset) begin
      if (bp_watch) check("busy_backpressure", {31'h0, busy}, 32'h1);
      if (rsp_valid) begin
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
          check("rsp_latency", 32'(cyc - mon_e.acc), 32'(W + 1));
        end
      end else if (q.size() > 0 && cyc >= q[0].acc) begin
        check("req_ready_low", {31'h0, req_ready}, 32'h0);
        check("busy_high", {31'h0, busy}, 32'h1);
      end
    end
  end

  task automatic send(input logic w, input logic [8:0] a, input logic [31:0] d,
                      input logic [2:0] f3, output int acc);
    exp_t e;
    int g = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    model(w, a, d, f3, e.rdata, e.err);
    e.acc = cyc + 1;
    acc = e.acc;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int a1, a2;
    logic [31:0] mis_exp;
    for (int i = 0; i < 512; i++) mb[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'h0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    // Clear every word so DUT and model agree on initial contents.
    for (int i = 0; i < 128; i++) send(1'b1, 9'(i * 4), 32'h0, 3'b010, a1);
    drain();

    send(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, a1);
    send(1'b0, 9'h010, 32'h0, 3'b010, a1); drain();
    check("tp_lw", last_rdata, 32'hDEADBEEF);
    send(1'b1, 9'h011, 32'h00000080, 3'b000, a1);
    send(1'b0, 9'h011, 32'h0, 3'b000, a1); drain();
    check("tp_lb", last_rdata, 32'hFFFFFF80);
    send(1'b0, 9'h011, 32'h0, 3'b100, a1); drain();
    check("tp_lbu", last_rdata, 32'h00000080);
    send(1'b0, 9'h010, 32'h0, 3'b010, a1); drain();
    check("tp_lw_merge", last_rdata, 32'hDEAD80EF);
    send(1'b1, 9'h022, 32'h00008001, 3'b001, a1);
    send(1'b0, 9'h022, 32'h0, 3'b001, a1); drain();
    check("tp_lh", last_rdata, 32'hFFFF8001);
    send(1'b0, 9'h022, 32'h0, 3'b101, a1); drain();
    check("tp_lhu", last_rdata, 32'h00008001);
    send(1'b0, 9'h020, 32'h0, 3'b010, a1); drain();
    check("tp_lw_half", last_rdata, 32'h80010000);
    send(1'b1, 9'h010, 32'h11223344, 3'b010, a1);
    send(1'b0, 9'h013, 32'h0, 3'b010, a1); drain();
`ifdef DMEM_MISALIGN_ERR_EN
    mis_exp = 32'h0;
    check("tp_mis_err", {31'h0, last_err}, 32'h1);
`else
    mis_exp = 32'h11223344;
    check("tp_mis_err", {31'h0, last_err}, 32'h0);
`endif
    check("tp_mis_rdata", last_rdata, mis_exp);

    // Backpressure: second request held during the first one's wait states.
    send(1'b1, 9'h030, 32'hCAFEF00D, 3'b010, a1);
    bp_watch = 1'b1;
    send(1'b0, 9'h030, 32'h0, 3'b010, a2);
    bp_watch = 1'b0;
    check("bp_accept_gap", 32'(a2 - a1), 32'(W + 3));
    drain();

    // Reset during WAIT discards the latched store.
    send(1'b1, 9'h040, 32'h12345678, 3'b010, a1); drain();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h040;
    req_wdata = 32'hAAAAAAAA; req_funct3 = 3'b010;
    @(posedge clk); #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_rdata", rsp_rdata, 32'h0);
    repeat (6) @(negedge clk);
    send(1'b0, 9'h040, 32'h0, 3'b010, a1); drain();
    check("midrst_lw", last_rdata, 32'h12345678);

    // Random traffic over a small window to force address collisions.
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 9'($urandom_range(0, 63)), $urandom,
           3'($urandom_range(0, 7)), a1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
